// File: rtl/qam16_mapper_if.sv
// rtl/qam16_mapper_if.sv - byte-in / QAM-symbol-out stream bundle for qam16_mapper
interface qam16_mapper_if #(
    parameter int W = 16
);
    logic [7:0]          s_data;
    logic                s_valid;
    logic                s_ready;
    logic signed [W-1:0] m_i;
    logic signed [W-1:0] m_q;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_i, m_q, m_valid, m_last
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_i, m_q, m_valid, m_last
    );
endinterface

// File: rtl/qam16_mapper.sv
// rtl/qam16_mapper.sv - 16-QAM nibble mapper with OFDM symbol framing
// QAM_GRAY_EN selects the Gray level map; undefined gives the binary map.
module qam16_mapper #(
    parameter int W   = 16,
    parameter int N   = 8,
    parameter int AMP = 16'h1000
) (
    input  logic           aclk,
    input  logic           aresetn,
    qam16_mapper_if.slave  bus
);
    localparam int CW = $clog2(N);

    localparam logic signed [W-1:0] L_P1 = W'(AMP);
    localparam logic signed [W-1:0] L_P3 = W'(3 * AMP);
    localparam logic signed [W-1:0] L_N1 = W'(-AMP);
    localparam logic signed [W-1:0] L_N3 = W'(-3 * AMP);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_byte;
    logic signed [W-1:0] r_i;
    logic signed [W-1:0] r_q;
    logic                r_valid;
    logic                r_last;
    logic [CW-1:0]       r_cnt;

    logic                w_adv;
    logic                w_hs;
    logic                w_s_ready;
    logic                w_accept;
    logic                w_load;
    logic [3:0]          w_nib;
    logic [CW-1:0]       w_cnt_nxt;

    function automatic logic signed [W-1:0] level(input logic [1:0] b);
`ifdef QAM_GRAY_EN
        case (b)
            2'b00:   level = L_N3;
            2'b01:   level = L_N1;
            2'b11:   level = L_P1;
            default: level = L_P3;
        endcase
`else
        case (b)
            2'b00:   level = L_N3;
            2'b01:   level = L_N1;
            2'b10:   level = L_P1;
            default: level = L_P3;
        endcase
`endif
    endfunction

    // s_ready looks only at registered state and m_ready, never at s_valid
    always_comb begin
        w_adv     = !r_valid | bus.m_ready;
        w_hs      = r_valid & bus.m_ready;
        w_s_ready = (r_state == ST_EMPTY) | ((r_state == ST_LO) & w_adv);
        w_accept  = bus.s_valid & w_s_ready;
        w_load    = w_adv & (r_state != ST_EMPTY);
        w_nib     = (r_state == ST_HI) ? r_byte[7:4] : r_byte[3:0];
        w_cnt_nxt = r_cnt;
        if (w_hs) begin
            w_cnt_nxt = (r_cnt == CW'(N - 1)) ? '0 : r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_HI;
            ST_HI:    if (w_adv)    w_state_nxt = ST_LO;
            ST_LO:    if (w_adv)    w_state_nxt = w_accept ? ST_HI : ST_EMPTY;
            default:                w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_EMPTY;
            r_byte  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_byte <= bus.s_data;
        end
    end

    // m_last is computed from the post-handshake count so it tags the symbol being loaded
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid <= 1'b0;
            r_i     <= '0;
            r_q     <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_adv) begin
                r_valid <= w_load;
                if (w_load) begin
                    r_i    <= level(w_nib[3:2]);
                    r_q    <= level(w_nib[1:0]);
                    r_last <= (w_cnt_nxt == CW'(N - 1));
                end else begin
                    r_last <= 1'b0;
                end
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_i     = r_i;
    assign bus.m_q     = r_q;
    assign bus.m_valid = r_valid;
    assign bus.m_last  = r_last;
endmodule

// File: tb/tb_qam16_mapper.sv
// tb/tb_qam16_mapper.sv - scoreboard bench for qam16_mapper (honours QAM_GRAY_EN)
module tb_qam16_mapper;
    localparam int W   = 16;
    localparam int N   = 8;
    localparam int AMP = 16'h1000;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        last;
        logic [31:0] cyc;
    } sym_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;
    int   cyc      = 0;
    sym_t exp_q[$];
    sym_t obs_q[$];

    always #5 aclk = ~aclk;

    qam16_mapper_if #(.W(W)) bus ();

    qam16_mapper #(.W(W), .N(N), .AMP(AMP)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aresetn && bus.m_valid && bus.m_ready)
            obs_q.push_back(sym_t'{i: bus.m_i, q: bus.m_q, last: bus.m_last, cyc: cyc});
    end

    function automatic logic [15:0] model_level(input logic [1:0] b);
        int idx;
`ifdef QAM_GRAY_EN
        idx = int'({b[1], b[1] ^ b[0]});
`else
        idx = int'(b);
`endif
        return 16'((2 * idx - 3) * AMP);
    endfunction

    task automatic push_exp(input logic [7:0] b);
        sym_t s;
        for (int h = 0; h < 2; h++) begin
            logic [3:0] nib;
            nib    = (h == 0) ? b[7:4] : b[3:0];
            s.i    = model_level(nib[3:2]);
            s.q    = model_level(nib[1:0]);
            s.last = (exp_cnt == N - 1);
            s.cyc  = '0;
            exp_cnt = (exp_cnt + 1) % N;
            exp_q.push_back(s);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge aclk);
            if (bus.s_ready) begin
                push_exp(b);
                @(posedge aclk);
                #1;
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_byte_timeout byte=%h not accepted within 50 cycles", b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.s_valid = 1'b0;
        aresetn = 1'b0;
        idle(3);
        aresetn = 1'b1;
        exp_q.delete();
        obs_q.delete();
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        aresetn     = 1'b0;
        idle(3);
        @(negedge aclk);
        n_checks++;
        if (bus.m_valid !== 1'b0)
            begin n_errors++; $display("FAIL reset_hold_m_valid got=%b want=0", bus.m_valid); end
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (bus.m_valid !== 1'b0)
            begin n_errors++; $display("FAIL reset_m_valid got=%b want=0", bus.m_valid); end
        n_checks++;
        if (bus.m_i !== 16'h0000 || bus.m_q !== 16'h0000)
            begin n_errors++; $display("FAIL reset_iq got=%h/%h want=0000/0000", bus.m_i, bus.m_q); end
        n_checks++;
        if (bus.m_last !== 1'b0)
            begin n_errors++; $display("FAIL reset_m_last got=%b want=0", bus.m_last); end
        n_checks++;
        if (bus.s_ready !== 1'b1)
            begin n_errors++; $display("FAIL reset_s_ready got=%b want=1", bus.s_ready); end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_mapping();
        logic [15:0] hi_i, hi_q;
        sym_t o, e;
`ifdef QAM_GRAY_EN
        hi_i = 16'h3000; hi_q = 16'h1000;
`else
        hi_i = 16'h1000; hi_q = 16'h3000;
`endif
        bus.m_ready = 1'b1;
        send_byte(8'hB4);
        bus.s_valid = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (bus.m_valid !== 1'b0)
            begin n_errors++; $display("FAIL map_latency_early got=%b want=0", bus.m_valid); end
        @(negedge aclk);
        n_checks++;
        if ({bus.m_valid, bus.m_i, bus.m_q} !== {1'b1, hi_i, hi_q})
            begin n_errors++; $display("FAIL map_hi got=%b/%h/%h want=1/%h/%h", bus.m_valid, bus.m_i, bus.m_q, hi_i, hi_q); end
        @(negedge aclk);
        n_checks++;
        if ({bus.m_valid, bus.m_i, bus.m_q} !== {1'b1, 16'hF000, 16'hD000})
            begin n_errors++; $display("FAIL map_lo got=%b/%h/%h want=1/f000/d000", bus.m_valid, bus.m_i, bus.m_q); end
        @(negedge aclk);
        n_checks++;
        if (bus.m_valid !== 1'b0)
            begin n_errors++; $display("FAIL map_drain got=%b want=0", bus.m_valid); end
        @(posedge aclk);
        #1;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if ({o.i, o.q, o.last} !== {e.i, e.q, e.last})
                begin n_errors++; $display("FAIL map_sb got=%h/%h/%b want=%h/%h/%b", o.i, o.q, o.last, e.i, e.q, e.last); end
        end
        n_checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0)
            begin n_errors++; $display("FAIL map_count left_obs=%0d left_exp=%0d want=0/0", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] nb;
        logic       acc;
        sym_t o, e;
        do_reset();
        bus.m_ready = 1'b1;
        nb          = 8'h00;
        bus.s_data  = nb;
        bus.s_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge aclk);
            acc = 1'b0;
            n_checks++;
            if (bus.s_ready !== logic'(c % 2 == 0))
                begin n_errors++; $display("FAIL b2b_s_ready cycle=%0d got=%b want=%b", c, bus.s_ready, logic'(c % 2 == 0)); end
            if (bus.s_valid && bus.s_ready) begin
                push_exp(nb);
                acc = 1'b1;
            end
            @(posedge aclk);
            #1;
            if (acc) begin
                if (nb == 8'h07) bus.s_valid = 1'b0;
                else begin nb = nb + 8'h01; bus.s_data = nb; end
            end
        end
        bus.s_valid = 1'b0;
        idle(4);
        n_checks++;
        if (obs_q.size() != 16)
            begin n_errors++; $display("FAIL b2b_count got=%0d want=16", obs_q.size()); end
        for (int k = 1; k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k].cyc !== obs_q[0].cyc + 32'(k))
                begin n_errors++; $display("FAIL b2b_rate sym=%0d cyc=%0d want=%0d", k, obs_q[k].cyc, obs_q[0].cyc + 32'(k)); end
        end
        for (int k = 0; k < obs_q.size(); k++) begin
            n_checks++;
            if (obs_q[k].last !== logic'(k == 7 || k == 15))
                begin n_errors++; $display("FAIL b2b_last sym=%0d got=%b want=%b", k, obs_q[k].last, logic'(k == 7 || k == 15)); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if ({o.i, o.q, o.last} !== {e.i, e.q, e.last})
                begin n_errors++; $display("FAIL b2b_sb got=%h/%h/%b want=%h/%h/%b", o.i, o.q, o.last, e.i, e.q, e.last); end
        end
        n_checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0)
            begin n_errors++; $display("FAIL b2b_left obs=%0d exp=%0d want=0/0", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_backpressure();
        sym_t o, e, held;
        bus.m_ready = 1'b0;
        send_byte(8'hFF);
        bus.s_valid = 1'b0;
        @(posedge aclk);
        #1;
        held = exp_q[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            n_checks++;
            if ({bus.m_valid, bus.m_i, bus.m_q, bus.m_last} !== {1'b1, held.i, held.q, held.last})
                begin n_errors++; $display("FAIL bp_hold cycle=%0d got=%b/%h/%h/%b want=1/%h/%h/%b", c, bus.m_valid, bus.m_i, bus.m_q, bus.m_last, held.i, held.q, held.last); end
            n_checks++;
            if (bus.s_ready !== 1'b0)
                begin n_errors++; $display("FAIL bp_s_ready cycle=%0d got=%b want=0", c, bus.s_ready); end
        end
        @(posedge aclk);
        #1 bus.m_ready = 1'b1;
        idle(4);
        n_checks++;
        if (obs_q.size() != 2)
            begin n_errors++; $display("FAIL bp_count got=%0d want=2", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if ({o.i, o.q, o.last} !== {e.i, e.q, e.last})
                begin n_errors++; $display("FAIL bp_sb got=%h/%h/%b want=%h/%h/%b", o.i, o.q, o.last, e.i, e.q, e.last); end
        end
        n_checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0)
            begin n_errors++; $display("FAIL bp_left obs=%0d exp=%0d want=0/0", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        sym_t o, e;
        bit   seen;
        bus.m_ready = 1'b1;
        send_byte(8'h5A);
        bus.s_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge aclk);
            if (obs_q.size() >= 1) seen = 1'b1;
        end
        n_checks++;
        if (!seen)
            begin n_errors++; $display("FAIL rstmid_hi_timeout got=none want=HI symbol of 5a"); end
        @(posedge aclk);
        #1 aresetn = 1'b0;
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q[0];
            e = exp_q[0];
            n_checks++;
            if ({o.i, o.q, o.last} !== {e.i, e.q, e.last})
                begin n_errors++; $display("FAIL rstmid_hi got=%h/%h/%b want=%h/%h/%b", o.i, o.q, o.last, e.i, e.q, e.last); end
        end
        @(negedge aclk);
        n_checks++;
        if (bus.m_valid !== 1'b0)
            begin n_errors++; $display("FAIL rstmid_flush got=%b want=0", bus.m_valid); end
        idle(2);
        aresetn = 1'b1;
        exp_q.delete();
        obs_q.delete();
        exp_cnt = 0;
        idle(3);
        n_checks++;
        if (obs_q.size() != 0 || bus.m_valid !== 1'b0)
            begin n_errors++; $display("FAIL rstmid_lo_leak got=%0d/%b want=0/0", obs_q.size(), bus.m_valid); end
        for (int b = 0; b < 4; b++) send_byte(8'(b));
        bus.s_valid = 1'b0;
        idle(6);
        n_checks++;
        if (obs_q.size() != 8)
            begin n_errors++; $display("FAIL rstmid_count got=%0d want=8", obs_q.size()); end
        if (obs_q.size() == 8) begin
            n_checks++;
            if ({obs_q[0].i, obs_q[0].q, obs_q[0].last} !== {16'hD000, 16'hD000, 1'b0})
                begin n_errors++; $display("FAIL rstmid_first got=%h/%h/%b want=d000/d000/0", obs_q[0].i, obs_q[0].q, obs_q[0].last); end
            n_checks++;
            if ({obs_q[6].last, obs_q[7].last} !== 2'b01)
                begin n_errors++; $display("FAIL rstmid_last got=%b%b want=01", obs_q[6].last, obs_q[7].last); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if ({o.i, o.q, o.last} !== {e.i, e.q, e.last})
                begin n_errors++; $display("FAIL rstmid_sb got=%h/%h/%b want=%h/%h/%b", o.i, o.q, o.last, e.i, e.q, e.last); end
        end
        n_checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0)
            begin n_errors++; $display("FAIL rstmid_left obs=%0d exp=%0d want=0/0", obs_q.size(), exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mapping();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
